// File: rtl/input_conditioner_pkg.sv
// Shared defaults for the pad input conditioner (50 MHz board clock) and a counter width helper.
package input_conditioner_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms
    localparam int DEF_RESET_HOLD      = 50_000_000;  // 1 s

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pad input: two-flop synchroniser, consecutive-cycle debounce and registered edge pulses.
// Latency DEBOUNCE_CYCLES+1 edges from first sampling edge to level/pulse; no backpressure.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differ;

    assign differ = sync[1] != level;
    // flip is the decision taken at the coming edge; the top needs it to act in the same cycle
    assign flip   = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= flip && !level;
            fall <= flip && level;
            if (flip) begin
                level <= !level;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw buttons/switches into debounced levels, edge pulses, auto-repeat and hold-to-reset.
// Latency DEBOUNCE_CYCLES+1 edges from first sampling edge; no backpressure.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int RESET_BTN       = 3,
    parameter int RESET_HOLD      = DEF_RESET_HOLD
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] button_raw,
    input  logic [N_SW-1:0]  switch_raw,
    output logic [N_BTN-1:0] button_level,
    output logic [N_BTN-1:0] button_pulse,
    output logic [N_BTN-1:0] button_release,
    output logic [N_BTN-1:0] button_repeat,
    output logic [N_SW-1:0]  switch_level,
    output logic [N_SW-1:0]  switch_changed,
    output logic             reset_out
);

    logic [N_BTN-1:0] btn_flip;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;
    logic [N_SW-1:0]  sw_flip;
    logic             unused_flips;

    // switches never look ahead; btn_flip is only consumed when auto-repeat is built
    assign unused_flips = ^{sw_flip, btn_flip};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .clock (clock),
            .reset (reset),
            .raw   (button_raw[i]),
            .level (button_level[i]),
            .rise  (button_pulse[i]),
            .fall  (button_release[i]),
            .flip  (btn_flip[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .clock (clock),
            .reset (reset),
            .raw   (switch_raw[i]),
            .level (switch_level[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .flip  (sw_flip[i])
        );
    end

    assign switch_changed = sw_rise | sw_fall;

    if (REPEAT_EN != 0) begin : g_rep
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = cnt_width(RMAX);

        for (genvar b = 0; b < N_BTN; b++) begin : g_rpt_b
            logic [RW-1:0] rep_cnt;
            logic          rpt;

            assign button_repeat[b] = rpt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rep_cnt <= '0;
                    rpt     <= 1'b0;
                end else if (btn_flip[b] && !button_level[b]) begin
                    rep_cnt <= RW'(REPEAT_DELAY - 1);
                    rpt     <= 1'b1;
                end else if (button_level[b] && !btn_flip[b]) begin
                    if (rep_cnt == '0) begin
                        rep_cnt <= RW'(REPEAT_PERIOD - 1);
                        rpt     <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - 1'b1;
                        rpt     <= 1'b0;
                    end
                end else begin
                    // released, or releasing this edge: drop anything pending
                    rep_cnt <= '0;
                    rpt     <= 1'b0;
                end
            end
        end
    end else begin : g_no_rep
        assign button_repeat = button_pulse;
    end

    if (RESET_HOLD > 0) begin : g_hold
        localparam int HW = cnt_width(RESET_HOLD + 1);
        logic [HW-1:0] hold_cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                hold_cnt <= '0;
            end else if (!button_level[RESET_BTN]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HW'(RESET_HOLD)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end

        assign reset_out = button_level[RESET_BTN] && (hold_cnt == HW'(RESET_HOLD));
    end else begin : g_no_hold
        assign reset_out = 1'b0;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an edge-numbered scoreboard of expected pulses.
module tb_input_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] button_raw;
    logic [7:0] switch_raw;
    logic [3:0] button_level;
    logic [3:0] button_pulse;
    logic [3:0] button_release;
    logic [3:0] button_repeat;
    logic [7:0] switch_level;
    logic [7:0] switch_changed;
    logic       reset_out;

    input_conditioner #(
        .N_BTN(4), .N_SW(8), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .RESET_BTN(3), .RESET_HOLD(8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .button_raw     (button_raw),
        .switch_raw     (switch_raw),
        .button_level   (button_level),
        .button_pulse   (button_pulse),
        .button_release (button_release),
        .button_repeat  (button_repeat),
        .switch_level   (switch_level),
        .switch_changed (switch_changed),
        .reset_out      (reset_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // sig: 0 press pulse, 1 release, 2 repeat, 3 switch change, 4 reset_out rise, 5 reset_out fall
    typedef struct {
        int edge_no;
        int sig;
        int idx;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_rst = 1'b0;

    function automatic string sig_name(input int s);
        case (s)
            0:       return "button_pulse";
            1:       return "button_release";
            2:       return "button_repeat";
            3:       return "switch_changed";
            4:       return "reset_out_rise";
            default: return "reset_out_fall";
        endcase
    endfunction

    function automatic logic obs_bit(input int s, input int i);
        case (s)
            0:       return button_pulse[i];
            1:       return button_release[i];
            2:       return button_repeat[i];
            3:       return switch_changed[i];
            4:       return reset_out && !prev_rst;
            default: return !reset_out && prev_rst;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int s, input int i, input int e);
        ev_t ev;
        ev.edge_no = e;
        ev.sig     = s;
        ev.idx     = i;
        exp_q.push_back(ev);
    endtask

    // press at level edge p; repeats every 3 after a 10-edge delay while t < r; release at r if given
    task automatic exp_btn(input int i, input int p, input int r, input bit with_release);
        push(0, i, p);
        push(2, i, p);
        for (int t = p + 10; t < r; t += 3) push(2, i, t);
        if (with_release) push(1, i, r);
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        for (int s = 0; s < 6; s++) begin
            int n;
            n = (s == 3) ? 8 : ((s >= 4) ? 1 : 4);
            for (int i = 0; i < n; i++) begin
                logic o;
                logic e;
                e = 1'b0;
                o = obs_bit(s, i);
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (exp_q[k].edge_no == cyc && exp_q[k].sig == s && exp_q[k].idx == i) begin
                        e = 1'b1;
                        exp_q.delete(k);
                    end
                end
                if (o || e) check($sformatf("%s[%0d]@edge%0d", sig_name(s), i, cyc), 32'(o), 32'(e));
            end
        end
        prev_rst = reset_out;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_button_level"},   32'(button_level),   0);
        check({pfx, "_button_pulse"},   32'(button_pulse),   0);
        check({pfx, "_button_release"}, 32'(button_release), 0);
        check({pfx, "_button_repeat"},  32'(button_repeat),  0);
        check({pfx, "_switch_level"},   32'(switch_level),   0);
        check({pfx, "_switch_changed"}, 32'(switch_changed), 0);
        check({pfx, "_reset_out"},      32'(reset_out),      0);
    endtask

    initial begin
        int c;
        int p;
        int r;
        int rr;
        int q;

        reset      = 1'b1;
        button_raw = '0;
        switch_raw = '0;
        run(3);
        check_all_zero("reset_state");
        reset = 1'b0;
        run(2);

        // clean press and release of button0
        c = cyc;
        p = c + 6;
        exp_btn(0, p, p + 8, 1'b1);
        button_raw[0] = 1'b1;
        run(5);
        check("b0_level_before_latency", 32'(button_level[0]), 0);
        tick();
        check("b0_level_at_latency", 32'(button_level[0]), 1);
        run(2);
        button_raw[0] = 1'b0;
        run(12);
        check("b0_level_after_release", 32'(button_level[0]), 0);

        // bouncing switch2 settles high with exactly one change pulse
        c = cyc;
        push(3, 2, c + 14);
        switch_raw[2] = 1'b1; run(2);
        switch_raw[2] = 1'b0; run(2);
        switch_raw[2] = 1'b1; run(2);
        switch_raw[2] = 1'b0; run(2);
        switch_raw[2] = 1'b1;
        run(5);
        check("sw2_level_before_settle", 32'(switch_level[2]), 0);
        tick();
        check("sw2_level_settled", 32'(switch_level[2]), 1);
        c = cyc;
        push(3, 2, c + 6);
        switch_raw[2] = 1'b0;
        run(10);

        // auto-repeat on button1; release lands on the edge of a due repeat
        c = cyc;
        p = c + 6;
        exp_btn(1, p, p + 31, 1'b1);
        button_raw[1] = 1'b1;
        run(31);
        button_raw[1] = 1'b0;
        run(12);

        // hold-to-reset on button3
        c = cyc;
        p = c + 6;
        exp_btn(3, p, p + 16, 1'b1);
        push(4, 0, p + 8);
        push(5, 0, p + 16);
        button_raw[3] = 1'b1;
        run(16);
        check("reset_out_held", 32'(reset_out), 1);
        button_raw[3] = 1'b0;
        run(10);

        // short 6-cycle hold must not request reset
        c = cyc;
        p = c + 6;
        exp_btn(3, p, c + 12, 1'b1);
        button_raw[3] = 1'b1;
        run(6);
        button_raw[3] = 1'b0;
        run(5);
        check("reset_out_short_hold", 32'(reset_out), 0);
        run(7);

        // asynchronous reset with button0 mid-count and button1 repeat pending
        c  = cyc;
        rr = c + 15;
        exp_btn(1, c + 6, rr + 1, 1'b0);
        button_raw[1] = 1'b1;
        run(10);
        button_raw[0] = 1'b1;
        run(5);
        check("b1_level_before_reset", 32'(button_level[1]), 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        run(2);
        reset = 1'b0;
        q = cyc;
        exp_btn(0, q + 6, q + 14, 1'b1);
        exp_btn(1, q + 6, q + 14, 1'b1);
        run(8);
        button_raw[0] = 1'b0;
        button_raw[1] = 1'b0;
        run(10);

        // all twelve inputs rise together
        c = cyc;
        p = c + 6;
        r = p + 7;
        for (int i = 0; i < 4; i++) exp_btn(i, p, r, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push(3, i, p);
            push(3, i, r);
        end
        button_raw = 4'hF;
        switch_raw = 8'hFF;
        run(6);
        check("simul_button_level",   32'(button_level),   32'hF);
        check("simul_switch_level",   32'(switch_level),   32'hFF);
        check("simul_button_pulse",   32'(button_pulse),   32'hF);
        check("simul_switch_changed", 32'(switch_changed), 32'hFF);
        run(1);
        button_raw = '0;
        switch_raw = '0;
        run(12);
        check("simul_levels_cleared", 32'({button_level, switch_level}), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
